// File: rtl/instr_decode_queue.sv
// RV32I decode feeding a DEPTH-entry FIFO of {instr, pc, class, id, illegal}; one-cycle push-to-head latency, no bypass.
// in_ready_o falls only when full (a pop in that cycle does not free a slot); flush/reset empty the queue next cycle.
`ifndef INST_ID_LEN
`define INST_ID_LEN  6
`define NONE_ID      6'd0
`define ADDI_ID      6'd1
`define SLTI_ID      6'd2
`define SLTIU_ID     6'd3
`define XORI_ID      6'd4
`define ORI_ID       6'd5
`define ANDI_ID      6'd6
`define SLLI_ID      6'd7
`define SRLI_ID      6'd8
`define SRAI_ID      6'd9
`define ADD_ID       6'd10
`define SUB_ID       6'd11
`define SLL_ID       6'd12
`define SLT_ID       6'd13
`define SLTU_ID      6'd14
`define XOR_ID       6'd15
`define SRL_ID       6'd16
`define SRA_ID       6'd17
`define OR_ID        6'd18
`define AND_ID       6'd19
`define LUI_ID       6'd20
`define AUIPC_ID     6'd21
`define LB_ID        6'd22
`define LH_ID        6'd23
`define LW_ID        6'd24
`define LBU_ID       6'd25
`define LHU_ID       6'd26
`define SB_ID        6'd27
`define SH_ID        6'd28
`define SW_ID        6'd29
`define BRANCH_ID    6'd30
`define JAL_ID       6'd31
`define JALR_ID      6'd32
`define MISC_MEM_ID  6'd33
`define SYSTEM_ID    6'd34
`endif

module instr_decode_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    flush_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [31:0]             instr_i,
   input  logic [XLEN-1:0]         pc_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [31:0]             instr_o,
   output logic [XLEN-1:0]         pc_o,
   output logic [3:0]              opclass_o,
   output logic [`INST_ID_LEN-1:0] instr_id_o,
   output logic                    illegal_o,
   output logic [CNT_W-1:0]        count_o
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   logic [3:0] dec_cls;
   logic [`INST_ID_LEN-1:0] dec_id;
   logic dec_ill;

   assign opcode = instr_i[6:0];
   assign f3     = instr_i[14:12];
   assign f7     = instr_i[31:25];

   always_comb begin
      dec_cls = 4'd0;
      dec_id  = `NONE_ID;
      dec_ill = 1'b0;
      case (opcode)
         7'b0010011: begin
            dec_cls = 4'd1;
            case (f3)
               3'b000: dec_id = `ADDI_ID;
               3'b010: dec_id = `SLTI_ID;
               3'b011: dec_id = `SLTIU_ID;
               3'b100: dec_id = `XORI_ID;
               3'b110: dec_id = `ORI_ID;
               3'b111: dec_id = `ANDI_ID;
               3'b001: begin
                  dec_id  = `SLLI_ID;
                  dec_ill = (f7 != 7'b0000000);
               end
               default: begin
                  dec_id  = (f7 == 7'b0100000) ? `SRAI_ID : `SRLI_ID;
                  dec_ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
               end
            endcase
         end
         7'b0110011: begin
            dec_cls = 4'd2;
            if (f7 == 7'b0000000) begin
               case (f3)
                  3'b000:  dec_id = `ADD_ID;
                  3'b001:  dec_id = `SLL_ID;
                  3'b010:  dec_id = `SLT_ID;
                  3'b011:  dec_id = `SLTU_ID;
                  3'b100:  dec_id = `XOR_ID;
                  3'b101:  dec_id = `SRL_ID;
                  3'b110:  dec_id = `OR_ID;
                  default: dec_id = `AND_ID;
               endcase
            end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
               dec_id = `SUB_ID;
            end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
               dec_id = `SRA_ID;
            end else begin
               dec_ill = 1'b1;
            end
         end
         7'b0110111: begin dec_cls = 4'd3; dec_id = `LUI_ID;   end
         7'b0010111: begin dec_cls = 4'd4; dec_id = `AUIPC_ID; end
         7'b0000011: begin
            dec_cls = 4'd5;
            case (f3)
               3'b000:  dec_id = `LB_ID;
               3'b001:  dec_id = `LH_ID;
               3'b010:  dec_id = `LW_ID;
               3'b100:  dec_id = `LBU_ID;
               3'b101:  dec_id = `LHU_ID;
               default: dec_ill = 1'b1;
            endcase
         end
         7'b0100011: begin
            dec_cls = 4'd6;
            case (f3)
               3'b000:  dec_id = `SB_ID;
               3'b001:  dec_id = `SH_ID;
               3'b010:  dec_id = `SW_ID;
               default: dec_ill = 1'b1;
            endcase
         end
         7'b1100011: begin
            dec_cls = 4'd7;
            dec_id  = `BRANCH_ID;
            dec_ill = (f3 == 3'b010) || (f3 == 3'b011);
         end
         7'b1101111: begin dec_cls = 4'd8; dec_id = `JAL_ID; end
         7'b1100111: begin
            dec_cls = 4'd9;
            dec_id  = `JALR_ID;
            dec_ill = (f3 != 3'b000);
         end
         7'b0001111: begin dec_cls = 4'd10; dec_id = `MISC_MEM_ID; end
         7'b1110011: begin dec_cls = 4'd11; dec_id = `SYSTEM_ID;   end
         default:    dec_ill = 1'b1;
      endcase
      if (dec_ill) begin
         dec_cls = 4'd0;
         dec_id  = `NONE_ID;
      end
   end

   logic [31:0]             instr_q [DEPTH];
   logic [XLEN-1:0]         pc_q    [DEPTH];
   logic [3:0]              cls_q   [DEPTH];
   logic [`INST_ID_LEN-1:0] id_q    [DEPTH];
   logic                    ill_q   [DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic                    push, pop;

   assign in_ready_o  = (count_q != CNT_W'(DEPTH));
   assign out_valid_o = (count_q != '0);
   assign push        = in_valid_i & in_ready_o;
   assign pop         = out_valid_o & out_ready_i;

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) count_d = count_q + CNT_W'(1);
      if (pop && !push) count_d = count_q - CNT_W'(1);
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset: it is only observed while out_valid_o is high.
   always_ff @(posedge clk_i) begin
      if (push && !flush_i && !rst_i) begin
         instr_q[wr_ptr_q] <= instr_i;
         pc_q[wr_ptr_q]    <= pc_i;
         cls_q[wr_ptr_q]   <= dec_cls;
         id_q[wr_ptr_q]    <= dec_id;
         ill_q[wr_ptr_q]   <= dec_ill;
      end
   end

   assign instr_o    = instr_q[rd_ptr_q];
   assign pc_o       = pc_q[rd_ptr_q];
   assign opclass_o  = cls_q[rd_ptr_q];
   assign instr_id_o = id_q[rd_ptr_q];
   assign illegal_o  = ill_q[rd_ptr_q];
   assign count_o    = count_q;
endmodule
